// File: rtl/add_pipe.sv
// add_pipe: pipelined add/sub/accumulate datapath with valid/ready handshakes on both sides.
// Ports: clk, rst_n (async active-low); in_valid/in_ready with a, b (WIDTH) and mode
// (00 add, 01 sub, 10 accumulate, 11 clear); out_valid/out_ready with sum (WIDTH+1);
// ovf (sticky accumulator overflow); count (accepted transactions, 8-bit wrapping).
// Optional macro ADD_PIPE_SAT_EN: accumulate saturates at all-ones instead of wrapping.
module add_pipe #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             ovf,
  output logic [7:0]       count
);
  localparam int RW  = WIDTH + 1;
  localparam int RW1 = WIDTH + 2;
  logic [RW-1:0]     data_q [STAGES];
  logic [RW-1:0]     data_d [STAGES];
  logic [STAGES-1:0] vld_q, vld_d;
  logic [RW-1:0]     acc_q, acc_d, acc_nx, res;
  logic [RW1-1:0]    acc_full;
  logic              ovf_q, ovf_d, en, acc_ld;
  logic [7:0]        count_q, count_d;
  always_comb begin
    en       = !vld_q[STAGES-1] || out_ready;
    acc_ld   = in_valid && en;
    // One extra bit above RW exposes the true carry for the overflow flag.
    acc_full = RW1'(acc_q) + RW1'(a) + RW1'(b);
`ifdef ADD_PIPE_SAT_EN
    acc_nx   = acc_full[RW] ? '1 : acc_full[RW-1:0];
`else
    acc_nx   = acc_full[RW-1:0];
`endif
    res      = mode == 2'b00 ? RW'(a) + RW'(b) :
               mode == 2'b01 ? RW'(a) - RW'(b) :
               mode == 2'b10 ? acc_nx : '0;
    acc_d    = acc_ld && mode == 2'b10 ? acc_nx :
               acc_ld && mode == 2'b11 ? '0 : acc_q;
    ovf_d    = acc_ld && mode == 2'b10 ? ovf_q | acc_full[RW] :
               acc_ld && mode == 2'b11 ? 1'b0 : ovf_q;
    count_d  = count_q + 8'(acc_ld);
    for (int i = 0; i < STAGES; i++) begin
      data_d[i] = data_q[i];
      vld_d[i]  = vld_q[i];
    end
    // The whole pipeline advances together; a stall freezes every stage.
    if (en) begin
      data_d[0] = acc_ld ? res : data_q[0];
      vld_d[0]  = in_valid;
      for (int i = 1; i < STAGES; i++) begin
        data_d[i] = data_q[i-1];
        vld_d[i]  = vld_q[i-1];
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) data_q[i] <= '0;
      vld_q   <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) data_q[i] <= data_d[i];
      vld_q   <= vld_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      count_q <= count_d;
    end
  end
  assign in_ready  = en;
  assign out_valid = vld_q[STAGES-1];
  assign sum       = data_q[STAGES-1];
  assign ovf       = ovf_q;
  assign count     = count_q;
endmodule

// File: tb/tb_add_pipe.sv
// tb_add_pipe: randomized and directed self-checking bench for add_pipe against a queue-based reference model.
module tb_add_pipe;
  localparam int WIDTH  = 4;
  localparam int STAGES = 2;
  localparam int RMAX   = 1 << (WIDTH + 1);
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic [1:0]       mode = 2'b00;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH:0]   sum;
  logic             ovf;
  logic [7:0]       count;
  int checks = 0;
  int errors = 0;
  int macc = 0;
  int movf = 0;
  int mcount = 0;
  int rq[$];
  int pq[$];
  int got[$];
  bit acc_fl;
  add_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .ovf(ovf), .count(count)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  function automatic int model(input int x, input int y, input int m);
    int t;
    mcount = (mcount + 1) % 256;
    if (m == 0) return x + y;
    if (m == 1) return (x - y + RMAX) % RMAX;
    if (m == 3) begin
      macc = 0;
      movf = 0;
      return 0;
    end
    t = macc + x + y;
    if (t >= RMAX) begin
      movf = 1;
`ifdef ADD_PIPE_SAT_EN
      t = RMAX - 1;
`else
      t = t - RMAX;
`endif
    end
    macc = t;
    return t;
  endfunction
  // Each entry carries its pipeline position; position STAGES means presented at the output.
  task automatic cycle();
    bit exp_ov, en_m;
    int s;
    @(negedge clk);
    exp_ov = rq.size() > 0 && pq[0] == STAGES;
    en_m   = !exp_ov || out_ready;
    check("out_valid", int'(out_valid), int'(exp_ov));
    check("in_ready", int'(in_ready), int'(en_m));
    check("ovf", int'(ovf), movf);
    check("count", int'(count), mcount);
    s = int'(sum);
    if (exp_ov) check("sum", s, rq[0]);
    @(posedge clk);
    if (exp_ov && out_ready) begin
      got.push_back(s);
      void'(rq.pop_front());
      void'(pq.pop_front());
    end
    if (en_m) foreach (pq[i]) pq[i]++;
    acc_fl = in_valid && en_m;
    if (acc_fl) begin
      rq.push_back(model(int'(a), int'(b), int'(mode)));
      pq.push_back(1);
    end
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_sum", int'(sum), 0);
    check("rst_ovf", int'(ovf), 0);
    check("rst_count", int'(count), 0);
    check("rst_in_ready", int'(in_ready), 1);
    rq.delete();
    pq.delete();
    got.delete();
    macc = 0;
    movf = 0;
    mcount = 0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  task automatic one(input int x, input int y, input int m, input int exp, input string tag);
    in_valid = 1'b1;
    a = WIDTH'(x);
    b = WIDTH'(y);
    mode = 2'(m);
    cycle();
    in_valid = 1'b0;
    cycle();
    check({tag, "_valid"}, int'(out_valid), 1);
    check(tag, int'(sum), exp);
  endtask
  initial begin
    int nx, stall;
    bit seen;
    #1;
    check("init_out_valid", int'(out_valid), 0);
    check("init_in_ready", int'(in_ready), 1);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    one(0, 0, 3, 0, "clr0");
    one(15, 15, 2, 30, "acc1");
    one(3, 5, 1, 30, "sub_neg");
    one(5, 3, 1, 2, "sub_pos");
    one(1, 5, 0, 6, "add1");
    one(15, 15, 0, 30, "add_max");
    one(0, 0, 2, 30, "acc_kept");
`ifdef ADD_PIPE_SAT_EN
    one(15, 15, 2, 31, "acc_ovf");
`else
    one(15, 15, 2, 28, "acc_ovf");
`endif
    check("ovf_set", int'(ovf), 1);
    one(0, 0, 3, 0, "clr1");
    check("ovf_clr", int'(ovf), 0);
    // Backpressure: four adds with a three-cycle output stall after the first result.
    do_reset();
    nx = 1;
    stall = 0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      in_valid = nx <= 4;
      a = WIDTH'(nx);
      b = WIDTH'(nx);
      mode = 2'b00;
      out_ready = stall == 0;
      if (stall > 0) begin
        #1;
        check("bp_in_ready", int'(in_ready), 0);
        check("bp_hold", int'(sum), 2);
      end
      cycle();
      if (acc_fl) nx++;
      if (stall > 0) stall--;
      if (out_valid && !seen) begin
        seen = 1'b1;
        stall = 3;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("bp_n", got.size(), 4);
    for (int i = 0; i < 4; i++) check("bp_order", i < got.size() ? got[i] : -1, 2 * (i + 1));
    check("bp_count", int'(count), 4);
    // Throughput: one transaction per cycle, continuous output after the fill.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      a = WIDTH'(i);
      b = '0;
      mode = 2'b00;
      cycle();
      check("tp_accept", int'(acc_fl), 1);
      if (i >= 1) begin
        check("tp_cont", int'(out_valid), 1);
        check("tp_sum", int'(sum), i - 1);
      end
    end
    in_valid = 1'b0;
    repeat (3) cycle();
    check("tp_n", got.size(), 10);
    for (int i = 0; i < 10; i++) check("tp_order", i < got.size() ? got[i] : -1, i);
    check("tp_count", int'(count), 10);
    // Random traffic with a mid-stream reset.
    do_reset();
    for (int k = 0; k < 400; k++) begin
      in_valid = $urandom_range(0, 3) != 0;
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
      mode = $urandom_range(0, 2) == 0 ? 2'($urandom) : 2'b10;
      if ($urandom_range(0, 15) == 0) mode = 2'b11;
      out_ready = $urandom_range(0, 3) != 0;
      cycle();
      if (k == 200) do_reset();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (STAGES + 2) cycle();
    check("drain", rq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/add_pipe.md
Name: add_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle registered adder.
- Operand pairs arrive through a valid/ready input handshake. Per-transaction mode selects add, subtract, accumulate or accumulator clear.
- Results leave through a valid/ready output handshake after a fixed pipeline latency, with full backpressure.
- Used as the arithmetic datapath stage between interface-driven stimulus and downstream consumers.

Parameters:
- WIDTH, 4, operand width in bits (1..32); result width RW = WIDTH+1.
- STAGES, 2, pipeline depth in register stages (1..4); equals accept-to-output latency.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand transaction present.
- in_ready  output  1  block can accept; transfer when in_valid && in_ready at posedge.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- mode  input  2  00 add, 01 sub, 10 accumulate, 11 clear accumulator.
- out_valid  output  1  result present at stage STAGES.
- out_ready  input  1  consumer accepts; transfer when out_valid && out_ready at posedge.
- sum  output  RW  result.
- ovf  output  1  sticky accumulator overflow flag.
- count  output  8  accepted-transaction counter.

Behaviour:
- Reset (async assert, sync-to-clk release): all stage valid bits 0; stage data 0; accumulator 0; ovf 0; count 0.
  - Outputs during reset: out_valid=0, sum=0, ovf=0, count=0, in_ready=1.
- Stall control: en = !out_valid || out_ready; in_ready = en (combinational).
  - When en=0, every stage holds data and valid. No bubble collapsing; the whole pipeline advances together.
- Accept: at posedge with in_valid && in_ready, stage 1 captures the computed result and valid=1.
  - With en=1 and no accept, stage 1 valid becomes 0 (bubble).
- Latency: result of a transaction accepted at edge N appears on sum with out_valid=1 after edge N+STAGES-1, provided there is no stall. Stalls add cycles one-for-one.
- Stage-1 arithmetic by mode:
  - 00: sum = {0,a} + {0,b}, unsigned, exact in RW bits.
  - 01: sum = {0,a} - {0,b}, two's complement, RW bits (3-5 -> 5'b11110).
  - 10: acc_next = acc + a + b, modulo 2^RW. acc <= acc_next; sum = acc_next.
    - ovf set to 1 if the true sum ≥ 2^RW; ovf is sticky.
  - 11: acc <= 0, ovf <= 0, sum = 0.
- Accumulator and ovf change only on an accepted transaction; add/sub do not disturb acc.
- count increments by 1 per accepted transaction and wraps 255->0. A clear (mode 11) does not reset count.
- Backpressure: out_valid held high with stable sum until out_ready=1. No transaction is lost or duplicated.
- Simultaneous output handshake and input accept in the same cycle is allowed; throughput is 1 transaction/cycle when out_ready=1.
- Reset mid-operation: in-flight results are discarded; out_valid drops asynchronously; acc, ovf and count return to 0.
- in_valid, a, b and mode are ignored when in_ready=0.

Optional Feature:
- Macro ADD_PIPE_SAT_EN.
- Defined: accumulate saturates. If the true sum ≥ 2^RW, acc and sum = all-ones (2^RW-1) and ovf sets. Further accumulates stay at all-ones until mode 11. Add/sub are unaffected.
- Undefined: accumulate wraps modulo 2^RW as above; ovf still sets.

Test Plan (WIDTH=4, STAGES=2):
- Reset: hold rst_n=0 mid-stream -> out_valid=0, sum=0, ovf=0, count=0, in_ready=1 immediately, without waiting for a clk edge.
- Add: accept a=1,b=5,mode=00 at edge N -> out_valid=1, sum=6 after edge N+1; then a=15,b=15 -> sum=30.
- Sub: accept a=3,b=5,mode=01 -> sum=5'b11110; accept a=5,b=3 -> sum=2; acc unchanged, ovf=0.
- Accumulate: mode 11, then a=15,b=15,mode=10 twice -> sums 30, then 28 with ovf=1.
  - With ADD_PIPE_SAT_EN: second result is 31, ovf=1.
  - A following mode 11 -> sum=0, ovf=0.
- Backpressure: stream 4 adds (1+1, 2+2, 3+3, 4+4), out_ready=0 for 3 cycles after first out_valid.
  - Required: in_ready=0 during the stall; sum held at 2; then outputs 2, 4, 6, 8 in order, none dropped; count=4.
- Throughput: in_valid=1 and out_ready=1 for 10 cycles with a=i, b=0 -> out_valid continuous after 2-cycle fill, sum=0..9 in order, count=10.
